// File: rtl/branch_predictor.sv
// Direct-mapped BTB with saturating counters: IF-side lookup, ID-side training, mispredict/redirect, perf counters.
// Lookup, mispredict and redirect are combinational (zero cycles); table and stats change at the next clk edge.
// No backpressure: a stalled ID branch is ignored until it leaves ID, so each branch trains exactly once.
module branch_predictor #(
    parameter int WIDTH      = 32,
    parameter int ENTRIES    = 64,
    parameter int TAG_BITS   = 8,
    parameter int CTR_BITS   = 2,
    parameter int STAT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      if_pc,
    output logic                  pred_taken,
    output logic [WIDTH-1:0]      pred_target,
    input  logic                  stall,
    input  logic                  upd_valid,
    input  logic [WIDTH-1:0]      upd_pc,
    input  logic                  upd_taken,
    input  logic [WIDTH-1:0]      upd_target,
    input  logic                  upd_pred_taken,
    input  logic [WIDTH-1:0]      upd_pred_tgt,
    output logic                  mispredict,
    output logic [WIDTH-1:0]      redirect_pc,
    input  logic                  stat_clr,
    output logic [STAT_WIDTH-1:0] stat_branches,
    output logic [STAT_WIDTH-1:0] stat_mispred
);
    localparam int IDX = $clog2(ENTRIES);

    // Counter encodings: MSB set means "predict taken".
    localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(1) << (CTR_BITS - 1);
    localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_WT - CTR_BITS'(1);
    localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
    localparam logic [STAT_WIDTH-1:0] STAT_MAX = '1;

    // Table storage, one flop per field per entry.
    logic [ENTRIES-1:0]  valid_q, valid_d;
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [TAG_BITS-1:0] tag_d    [ENTRIES];
    logic [WIDTH-1:0]    target_q [ENTRIES];
    logic [WIDTH-1:0]    target_d [ENTRIES];
    logic [CTR_BITS-1:0] ctr_q    [ENTRIES];
    logic [CTR_BITS-1:0] ctr_d    [ENTRIES];

    logic [STAT_WIDTH-1:0] stat_branches_q, stat_branches_d;
    logic [STAT_WIDTH-1:0] stat_mispred_q, stat_mispred_d;

    // pc[1:0] never participates in index or tag.
    logic [IDX-1:0]      lk_idx, up_idx;
    logic [TAG_BITS-1:0] lk_tag, up_tag;
    logic                lk_hit, up_hit;
    logic                acc;

    assign lk_idx = if_pc[IDX+1:2];
    assign lk_tag = if_pc[IDX+1+TAG_BITS:IDX+2];
    assign up_idx = upd_pc[IDX+1:2];
    assign up_tag = upd_pc[IDX+1+TAG_BITS:IDX+2];

    assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    // Reads come from the registered table, so a same-cycle update to the same entry is not visible yet.
    assign pred_taken  = lk_hit && ctr_q[lk_idx][CTR_BITS-1];
    assign pred_target = lk_hit ? target_q[lk_idx] : if_pc + WIDTH'(4);

    // A branch held in ID by a stall is neither trained nor judged until it moves on.
    assign acc         = upd_valid && !stall && !rst;
    assign mispredict  = acc && ((upd_pred_taken != upd_taken) ||
                                 (upd_taken && (upd_pred_tgt != upd_target)));
    assign redirect_pc = upd_taken ? upd_target : upd_pc + WIDTH'(4);

    assign stat_branches = stat_branches_q;
    assign stat_mispred  = stat_mispred_q;

    // Table training: strengthen/weaken on hit, allocate only on a taken miss.
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        if (acc) begin
            if (up_hit) begin
                if (upd_taken) begin
                    target_d[up_idx] = upd_target;
                    if (ctr_q[up_idx] != CTR_MAX) begin
                        ctr_d[up_idx] = ctr_q[up_idx] + CTR_BITS'(1);
                    end
                end else if (ctr_q[up_idx] != '0) begin
                    ctr_d[up_idx] = ctr_q[up_idx] - CTR_BITS'(1);
                end
            end else if (upd_taken) begin
                valid_d[up_idx]  = 1'b1;
                tag_d[up_idx]    = up_tag;
                target_d[up_idx] = upd_target;
                ctr_d[up_idx]    = CTR_WT;
            end
        end
    end

    // Saturating perf counters; a clear beats a same-cycle increment.
    always_comb begin
        stat_branches_d = stat_branches_q;
        stat_mispred_d  = stat_mispred_q;
        if (stat_clr) begin
            stat_branches_d = '0;
            stat_mispred_d  = '0;
        end else begin
            if (acc && (stat_branches_q != STAT_MAX)) begin
                stat_branches_d = stat_branches_q + STAT_WIDTH'(1);
            end
            if (mispredict && (stat_mispred_q != STAT_MAX)) begin
                stat_mispred_d = stat_mispred_q + STAT_WIDTH'(1);
            end
        end
    end

    // Control state: valid bits, counters and stats return to their idle values on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q         <= '0;
            stat_branches_q <= '0;
            stat_mispred_q  <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= CTR_WNT;
            end
        end else begin
            valid_q         <= valid_d;
            ctr_q           <= ctr_d;
            stat_branches_q <= stat_branches_d;
            stat_mispred_q  <= stat_mispred_d;
        end
    end

    // Tag and target payload needs no reset: it is only observed behind a valid bit.
    always_ff @(posedge clk) begin
        tag_q    <= tag_d;
        target_q <= target_d;
    end

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;
    localparam int WIDTH    = 32;
    localparam int ENTRIES  = 16;
    localparam int TAG_BITS = 8;
    localparam int CTR_BITS = 2;
    localparam int STAT_W   = 4;
    localparam int CMAX     = (1 << CTR_BITS) - 1;
    localparam int CWT      = 1 << (CTR_BITS - 1);
    localparam int SMAX     = (1 << STAT_W) - 1;

    logic              clk;
    logic              rst;
    logic [WIDTH-1:0]  if_pc;
    logic              pred_taken;
    logic [WIDTH-1:0]  pred_target;
    logic              stall;
    logic              upd_valid;
    logic [WIDTH-1:0]  upd_pc;
    logic              upd_taken;
    logic [WIDTH-1:0]  upd_target;
    logic              upd_pred_taken;
    logic [WIDTH-1:0]  upd_pred_tgt;
    logic              mispredict;
    logic [WIDTH-1:0]  redirect_pc;
    logic              stat_clr;
    logic [STAT_W-1:0] stat_branches;
    logic [STAT_W-1:0] stat_mispred;

    int checks   = 0;
    int failures = 0;

    // Reference model: per-slot record with integer counters.
    bit          m_vld [ENTRIES];
    int unsigned m_tag [ENTRIES];
    logic [31:0] m_tgt [ENTRIES];
    int          m_ctr [ENTRIES];
    int          m_br;
    int          m_mp;

    branch_predictor #(
        .WIDTH(WIDTH), .ENTRIES(ENTRIES), .TAG_BITS(TAG_BITS),
        .CTR_BITS(CTR_BITS), .STAT_WIDTH(STAT_W)
    ) dut (
        .clk(clk), .rst(rst), .if_pc(if_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .stall(stall), .upd_valid(upd_valid), .upd_pc(upd_pc),
        .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_pred_taken(upd_pred_taken), .upd_pred_tgt(upd_pred_tgt),
        .mispredict(mispredict), .redirect_pc(redirect_pc),
        .stat_clr(stat_clr), .stat_branches(stat_branches), .stat_mispred(stat_mispred)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int m_idx(input logic [31:0] pc);
        return int'((pc / 32'd4) % ENTRIES);
    endfunction

    function automatic int unsigned m_tagof(input logic [31:0] pc);
        return (pc / (32'd4 * ENTRIES)) % (32'd1 << TAG_BITS);
    endfunction

    task automatic mdl_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_vld[i] = 1'b0;
            m_ctr[i] = CWT - 1;
        end
        m_br = 0;
        m_mp = 0;
    endtask

    task automatic mdl_lookup(input logic [31:0] pc, output logic tk, output logic [31:0] tg);
        int i;
        i = m_idx(pc);
        if (m_vld[i] && (m_tag[i] == m_tagof(pc))) begin
            tk = (m_ctr[i] >= CWT);
            tg = m_tgt[i];
        end else begin
            tk = 1'b0;
            tg = pc + 32'd4;
        end
    endtask

    task automatic mdl_update(input logic acc, input logic mis);
        int i;
        if (rst) begin
            mdl_reset();
            return;
        end
        if (acc) begin
            i = m_idx(upd_pc);
            if (m_vld[i] && (m_tag[i] == m_tagof(upd_pc))) begin
                if (upd_taken) begin
                    m_ctr[i] = (m_ctr[i] + 1 > CMAX) ? CMAX : m_ctr[i] + 1;
                    m_tgt[i] = upd_target;
                end else begin
                    m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
                end
            end else if (upd_taken) begin
                m_vld[i] = 1'b1;
                m_tag[i] = m_tagof(upd_pc);
                m_tgt[i] = upd_target;
                m_ctr[i] = CWT;
            end
        end
        if (stat_clr) begin
            m_br = 0;
            m_mp = 0;
        end else begin
            if (acc) m_br = (m_br + 1 > SMAX) ? SMAX : m_br + 1;
            if (mis) m_mp = (m_mp + 1 > SMAX) ? SMAX : m_mp + 1;
        end
    endtask

    // One clock: check combinational outputs against the model, take the edge, check stats.
    task automatic cycle();
        logic        e_tk, e_acc, e_mis;
        logic [31:0] e_tg, e_rd;
        #3;
        mdl_lookup(if_pc, e_tk, e_tg);
        e_acc = upd_valid && !stall && !rst;
        e_mis = e_acc && ((upd_pred_taken != upd_taken) ||
                          (upd_taken && (upd_pred_tgt != upd_target)));
        e_rd  = upd_taken ? upd_target : upd_pc + 32'd4;
        chk("pred_taken", 32'(pred_taken), 32'(e_tk));
        chk("pred_target", pred_target, e_tg);
        chk("mispredict", 32'(mispredict), 32'(e_mis));
        chk("redirect_pc", redirect_pc, e_rd);
        @(posedge clk);
        mdl_update(e_acc, e_mis);
        #1;
        chk("stat_branches", 32'(stat_branches), 32'(m_br));
        chk("stat_mispred", 32'(stat_mispred), 32'(m_mp));
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] p;
        case ($urandom_range(0, 9))
            0:       p = 32'hFFFF_FFFC;
            1, 2:    p = 32'hFFFF_F000 + 32'($urandom_range(0, 47)) * 32'd4;
            default: p = 32'($urandom_range(0, 47)) * 32'd4;
        endcase
        return p | 32'($urandom_range(0, 3));
    endfunction

    initial begin
        logic        r_tk;
        logic [31:0] r_tg;

        rst = 1'b1; if_pc = '0; stall = 1'b0; upd_valid = 1'b0; upd_pc = '0;
        upd_taken = 1'b0; upd_target = '0; upd_pred_taken = 1'b0; upd_pred_tgt = '0;
        stat_clr = 1'b0;
        mdl_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state: every lookup misses, stats are zero.
        if_pc = 32'h1234;
        #1;
        chk("rst_pred_taken", 32'(pred_taken), 32'h0);
        chk("rst_pred_target", pred_target, 32'h1238);
        chk("rst_stat_branches", 32'(stat_branches), 32'h0);
        chk("rst_mispredict", 32'(mispredict), 32'h0);
        cycle();
        if_pc = 32'hFFFF_FFFC;
        upd_valid = 1'b1; upd_pc = 32'hFFFF_FFFC; upd_taken = 1'b0;
        #1;
        chk("wrap_pred_target", pred_target, 32'h0);
        chk("wrap_redirect", redirect_pc, 32'h0);
        cycle();

        // First taken branch: mispredict, redirect, then predicted taken.
        upd_pc = 32'h40; upd_taken = 1'b1; upd_target = 32'h80;
        upd_pred_taken = 1'b0; upd_pred_tgt = 32'h44; if_pc = 32'h40;
        #1;
        chk("t2_mispredict", 32'(mispredict), 32'h1);
        chk("t2_redirect", redirect_pc, 32'h80);
        chk("t2_same_cycle_lookup", 32'(pred_taken), 32'h0);
        cycle();
        upd_valid = 1'b0;
        #1;
        chk("t2_pred_taken", 32'(pred_taken), 32'h1);
        chk("t2_pred_target", pred_target, 32'h80);

        // Counter saturation and hysteresis.
        upd_valid = 1'b1; upd_pred_taken = 1'b1; upd_pred_tgt = 32'h80;
        repeat (5) cycle();
        upd_taken = 1'b0;
        cycle();
        upd_valid = 1'b0;
        #1;
        chk("t3_after_one_nt", 32'(pred_taken), 32'h1);
        upd_valid = 1'b1;
        cycle();
        upd_valid = 1'b0;
        #1;
        chk("t3_after_two_nt", 32'(pred_taken), 32'h0);
        chk("t3_target_kept", pred_target, 32'h80);

        // Aliasing PCs share a slot and evict each other.
        for (int k = 0; k < 4; k++) begin
            logic [31:0] mine, other;
            mine  = (k % 2 == 0) ? 32'h40 + 32'd4 * ENTRIES : 32'h40;
            other = (k % 2 == 0) ? 32'h40 : 32'h40 + 32'd4 * ENTRIES;
            upd_valid = 1'b1; upd_pc = mine; upd_taken = 1'b1;
            upd_target = 32'h1000 * (k + 1); if_pc = mine;
            cycle();
            upd_valid = 1'b0; if_pc = other;
            #1;
            chk("t4_other_miss_taken", 32'(pred_taken), 32'h0);
            chk("t4_other_miss_target", pred_target, other + 32'd4);
            if_pc = mine;
            #1;
            chk("t4_mine_hit_target", pred_target, 32'h1000 * (k + 1));
        end

        // Stalled branch is evaluated once, when it leaves ID.
        stat_clr = 1'b1;
        cycle();
        stat_clr = 1'b0;
        upd_valid = 1'b1; upd_pc = 32'h100; upd_taken = 1'b1; upd_target = 32'h200;
        upd_pred_taken = 1'b0; upd_pred_tgt = 32'h104; if_pc = 32'h100; stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t5_stalled_mispredict", 32'(mispredict), 32'h0);
            cycle();
        end
        chk("t5_stalled_no_write", 32'(pred_taken), 32'h0);
        stall = 1'b0;
        #1;
        chk("t5_release_mispredict", 32'(mispredict), 32'h1);
        cycle();
        upd_valid = 1'b0;
        #1;
        chk("t5_one_branch", 32'(stat_branches), 32'h1);
        chk("t5_one_mispred", 32'(stat_mispred), 32'h1);
        chk("t5_written_target", pred_target, 32'h200);

        // Stat saturation, then clear beating a same-cycle mispredict.
        upd_valid = 1'b1; upd_pc = 32'h200; upd_taken = 1'b1; upd_target = 32'h300;
        upd_pred_taken = 1'b0;
        repeat (16) cycle();
        chk("t6_mispred_sat", 32'(stat_mispred), 32'hF);
        chk("t6_branches_sat", 32'(stat_branches), 32'hF);
        stat_clr = 1'b1;
        #1;
        chk("t6_clr_cycle_mispredict", 32'(mispredict), 32'h1);
        cycle();
        stat_clr = 1'b0;
        chk("t6_clr_mispred", 32'(stat_mispred), 32'h0);
        chk("t6_clr_branches", 32'(stat_branches), 32'h0);

        // Mid-operation reset discards the concurrent update.
        rst = 1'b1; upd_pc = 32'h300; if_pc = 32'h300;
        #1;
        chk("rst_mid_mispredict", 32'(mispredict), 32'h0);
        cycle();
        rst = 1'b0; upd_valid = 1'b0;
        #1;
        chk("rst_mid_no_alloc", pred_target, 32'h304);
        if_pc = 32'h200;
        #1;
        chk("rst_mid_cleared", 32'(pred_taken), 32'h0);

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            rst       = ($urandom_range(0, 99) < 2);
            stall     = ($urandom_range(0, 3) == 0);
            upd_valid = ($urandom_range(0, 9) < 7);
            stat_clr  = ($urandom_range(0, 19) == 0);
            if_pc     = rand_pc();
            upd_pc    = rand_pc();
            upd_taken = $urandom_range(0, 1) == 1;
            upd_target = ($urandom_range(0, 1) == 1) ? 32'h8000 + 32'($urandom_range(0, 3)) * 32'd4
                                                     : $urandom();
            if ($urandom_range(0, 1) == 1) begin
                mdl_lookup(upd_pc, r_tk, r_tg);
                upd_pred_taken = r_tk;
                upd_pred_tgt   = r_tg;
            end else begin
                upd_pred_taken = $urandom_range(0, 1) == 1;
                upd_pred_tgt   = upd_target;
            end
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
